// File: rtl/rr_arbiter_4ch_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4ch_pkg
// Shared definitions for the 4-requester round-robin arbiter.
//   NUM_REQ     : number of requesters
//   IDX_W       : width of a requester index
//   arb_state_e : arbiter FSM state encoding (IDLE -> GRANT -> GAP -> IDLE)
// -----------------------------------------------------------------------------
package rr_arbiter_4ch_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

endpackage : rr_arbiter_4ch_pkg

// File: rtl/arb_idx_decoder.sv
// -----------------------------------------------------------------------------
// arb_idx_decoder
// Purely combinational index-to-one-hot decoder with enable.
// Ports:
//   idx_i  in  IDX_W    winner index
//   en_i   in  1        decode enable; output is all-zero when low
//   gnt_o  out NUM_REQ  one-hot grant (or zero)
// -----------------------------------------------------------------------------
module arb_idx_decoder
    import rr_arbiter_4ch_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            gnt_o[idx_i] = 1'b1;
        end
    end

endmodule : arb_idx_decoder

// File: rtl/rr_arbiter_4ch.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4ch
// 4-requester round-robin arbiter sharing one resource. A registered winner
// index is decoded into a one-hot grant while the FSM is in GRANT. A grant is
// held while its owner keeps requesting or until MAX_HOLD consecutive cycles
// have elapsed; every grant is followed by a one-cycle GAP and one IDLE cycle.
//
// Parameters:
//   MAX_HOLD  max consecutive GRANT cycles per grant; 0 = unlimited
//   HOLD_W    hold-counter width; must satisfy 2**HOLD_W > MAX_HOLD
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  level-sensitive request per master
//   lock     in   1  suppresses the MAX_HOLD exit while in GRANT
//                    (exists only when ARB_LOCK_EN is defined)
//   gnt      out  4  one-hot grant, zero when no grant is active
//   gnt_idx  out  2  index of the current/last winner
//   gnt_vld  out  1  high while a grant is active
//   busy     out  1  FSM is not in IDLE
//
// Configuration macro: ARB_LOCK_EN (adds the lock port).
// -----------------------------------------------------------------------------
module rr_arbiter_4ch
    import rr_arbiter_4ch_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               busy
);

    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q,    state_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;  // winner index, also the rotation pointer
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_limit;

    // First set request searching last+1, last+2, last+3, last+4 (mod 4).
    // The loop runs from the farthest candidate down so the nearest one wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] cand;
        rr_pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (r[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

    // Equality (not >=) against the limit: once lock has carried the count
    // past MAX_HOLD-1, only a dropped request ends the grant.
    always_comb begin
`ifdef ARB_LOCK_EN
        hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && !lock;
`else
        hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    last_idx_d = rr_pick(req, last_idx_q);
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (!req[last_idx_q] || hold_limit) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_idx_q <= '1;   // req[0] has first priority after reset
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Decoded from registers only, so reset clears gnt asynchronously.
    arb_idx_decoder u_dec (
        .idx_i (last_idx_q),
        .en_i  (state_q == ST_GRANT),
        .gnt_o (gnt)
    );

    assign gnt_idx = last_idx_q;
    assign gnt_vld = (state_q == ST_GRANT);
    assign busy    = (state_q != ST_IDLE);

endmodule : rr_arbiter_4ch

// File: tb/tb_rr_arbiter_4ch.sv
`timescale 1ns/1ps
module tb_rr_arbiter_4ch;

    localparam int MAXH = 4;
    localparam int HW   = 5;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       lock_r;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       busy;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];

    // reference model: 0 idle, 1 grant, 2 gap
    int m_st, m_idx, m_cnt;
    int wait_cnt[4];
    int max_wait = 0;

    always #5 clk = ~clk;

    rr_arbiter_4ch #(.MAX_HOLD(MAXH), .HOLD_W(HW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef ARB_LOCK_EN
        .lock    (lock_r),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_idx = 3;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    endtask

    // Advance the model by one rising edge given the sampled inputs.
    task automatic model_edge(input logic [3:0] r, input logic l);
        int   nxt;
        int   w;
        int   c;
        bit   lim;
        bit   lk;
        exp_t e;
`ifdef ARB_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
`endif
        nxt = m_st;
        for (int i = 0; i < 4; i++) if (!r[i]) wait_cnt[i] = 0;
        case (m_st)
            0: if (r != 4'b0) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_idx + k) % 4;
                    if (w < 0 && r[c]) w = c;
                end
                for (int i = 0; i < 4; i++) begin
                    if (i != w && r[i]) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
                wait_cnt[w] = 0;
                m_idx = w;
                m_cnt = 0;
                nxt   = 1;
            end
            1: begin
                lim = (MAXH != 0) && (m_cnt == MAXH - 1) && !lk;
                if (!r[m_idx] || lim) nxt = 2;
                if (m_cnt < (1 << HW) - 1) m_cnt++;
            end
            default: nxt = 0;
        endcase
        m_st   = nxt;
        e.gnt  = (m_st == 1) ? 4'(1 << m_idx) : 4'b0;
        e.idx  = 2'(m_idx);
        e.vld  = (m_st == 1);
        e.busy = (m_st != 0);
        sb_q.push_back(e);
    endtask

    // Drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic step(input logic [3:0] r, input logic l);
        exp_t e;
        req    = r;
        lock_r = l;
        @(posedge clk);
        model_edge(r, l);
        @(negedge clk);
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("gnt",     32'(gnt),     32'(e.gnt));
            check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            check("gnt_vld", 32'(gnt_vld), 32'(e.vld));
            check("busy",    32'(busy),    32'(e.busy));
        end
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        logic [3:0] rv;
        logic       lv;

        rst_n  = 1'b0;
        req    = 4'b0000;
        lock_r = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt",  32'(gnt),     32'h0);
        check("rst_idx",  32'(gnt_idx), 32'h3);
        check("rst_vld",  32'(gnt_vld), 32'h0);
        check("rst_busy", 32'(busy),    32'h0);
        rst_n = 1'b1;

        // all requesting: 0001, 0010, 0100, 1000, 0001 ... 4 cycles each, 2 zero cycles between
        for (int s = 0; s < 36; s++) begin
            step(4'b1111, 1'b0);
            exp_g = (s % 6 < 4) ? 4'(1 << ((s / 6) % 4)) : 4'b0000;
            check("rotation", 32'(gnt), 32'(exp_g));
        end
        idle_steps(2);

        // single request held 3 cycles then dropped
        for (int s = 0; s < 3; s++) begin
            step(4'b0100, 1'b0);
            check("hold3", 32'(gnt), 32'h4);
        end
        step(4'b0000, 1'b0);
        check("gap_gnt",  32'(gnt),  32'h0);
        check("gap_busy", 32'(busy), 32'h1);
        step(4'b0000, 1'b0);
        check("idle_gnt",  32'(gnt),  32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // two requesters held: hold limit forces rotation 0001 -> 0010
        for (int s = 0; s < 12; s++) begin
            step(4'b0011, 1'b0);
            exp_g = (s % 6 >= 4) ? 4'b0000 : ((s < 6) ? 4'b0001 : 4'b0010);
            check("maxhold", 32'(gnt), 32'(exp_g));
        end
        idle_steps(3);

`ifdef ARB_LOCK_EN
        // lock suppresses the hold limit
        for (int s = 0; s < 10; s++) begin
            step(4'b0001, 1'b1);
            check("lock_hold", 32'(gnt), 32'h1);
        end
        idle_steps(3);
`endif

        // single requester without lock: limited, then re-granted after GAP+IDLE
        for (int s = 0; s < 8; s++) begin
            step(4'b0001, 1'b0);
            exp_g = (s == 4 || s == 5) ? 4'b0000 : 4'b0001;
            check("single_regrant", 32'(gnt), 32'(exp_g));
        end
        idle_steps(3);

        // reset asserted mid-grant clears gnt without waiting for an edge
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt",  32'(gnt),     32'h0);
        check("async_vld",  32'(gnt_vld), 32'h0);
        check("async_busy", 32'(busy),    32'h0);
        check("async_idx",  32'(gnt_idx), 32'h3);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'h8);
        idle_steps(3);

        // after reset, a full request set is served from req[0]
        step(4'b1111, 1'b0);
        check("post_rst_first", 32'(gnt), 32'h1);
        idle_steps(6);

        // random traffic against the model
        rv = 4'b0000;
        lv = 1'b0;
        for (int s = 0; s < 10000; s++) begin
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) lv = 1'($urandom_range(0, 1));
            step(rv, lv);
        end

        check("starvation_ok", 32'(max_wait <= 3), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_rr_arbiter_4ch
